irq_arbiter: RTL and testbench
==============================

Name: irq_arbiter

Overview:
- Multi-source machine external-interrupt controller. It feeds the single `interrupt` input of the exception unit.
- Collects NUM_SRC interrupt lines and latches them as level or edge pending bits. Masks them with an enable register and picks one source by round-robin.
- Runs a raise / ack / complete handshake with the core, so only one external interrupt is in service at a time.
- Configured through a small word-addressed register port driven by the MEM stage.

Parameters:
- NUM_SRC, 8, number of interrupt sources (2..32).
- ID_W, 3, width of source id; must equal clog2(NUM_SRC).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- src_irq  in  NUM_SRC  raw interrupt lines, already synchronous to clk.
- irq_out  out  1  to exception unit `interrupt`; registered.
- irq_id  out  ID_W  id of the source currently raised or in service; registered.
- irq_ack  in  1  one-cycle pulse: core has taken the interrupt trap.
- irq_complete  in  1  one-cycle pulse: core executed mret for the interrupt handler.
- cfg_we  in  1  register write strobe.
- cfg_addr  in  4  byte address; bits [1:0] ignored.
- cfg_wdata  in  32  write data.
- cfg_rdata  out  32  read data; combinational from cfg_addr.

Behaviour:
- Register map:
  - 0x0 ENABLE (RW, NUM_SRC bits).
  - 0x4 EDGE (RW; 1 = edge-triggered, 0 = level).
  - 0x8 PENDING (read; write-1-to-clear affects edge sources only).
  - 0xC CLAIM. Read returns {active (bit 31), zeros, irq_id}. A write of an id completes that interrupt.
  - Unused bits read 0.
- Reset (rst=0):
  - ENABLE, EDGE, PENDING = 0; src_d = 0; rr_ptr = 0.
  - State = IDLE; irq_out = 0; irq_id = 0.
  - Reset is honoured in any state; an in-service interrupt is dropped.
- Pending:
  - Level source: pending[i] <= src_irq[i] every cycle.
  - Edge source: set on src_irq[i] & ~src_d[i]. Cleared on claim of i or on a W1C write.
  - If set and clear occur in the same cycle, set wins.
- eligible = pending & ENABLE. While in service, the in-service source is additionally masked.
- FSM: IDLE -> ASSERT -> SERVICE -> IDLE.
  - IDLE:
    - If any eligible bit is set, pick the first set bit scanning upward from rr_ptr, wrapping at NUM_SRC-1 -> 0.
    - Register irq_id, set irq_out = 1, go to ASSERT.
    - Latency: src edge -> pending (1 cycle) -> irq_out (1 cycle) = 2 cycles.
  - ASSERT:
    - irq_out = 1; irq_id is held with no re-arbitration.
    - If eligible[irq_id] falls (level drop, enable cleared, or W1C) and irq_ack=0: irq_out = 0, back to IDLE.
    - On irq_ack: go to SERVICE, irq_out = 0. Clear pending[irq_id] if it is an edge source. rr_ptr <= (irq_id+1) mod NUM_SRC.
    - If irq_ack and loss of eligibility occur in the same cycle, ack wins.
  - SERVICE:
    - irq_out = 0 (no nesting).
    - Complete on irq_complete, or on a CLAIM write whose wdata[ID_W-1:0] == irq_id; a write with a mismatched id is ignored.
    - Complete -> IDLE. A new arbitration starts the next cycle, never in the same cycle.
  - irq_ack seen outside ASSERT is ignored; irq_complete seen outside SERVICE is ignored.
- A config write takes effect on the next cycle. A PENDING W1C and a CLAIM write are single-cycle actions.

Decomposition:
- Package irq_pkg holds:
  - register offsets (ENABLE/EDGE/PENDING/CLAIM);
  - the FSM state enum {IDLE, ASSERT, SERVICE};
  - constant MCAUSE_MEI = 32'h8000000B, for the bench.
- One sub-module, rr_picker: a combinational round-robin priority encoder with inputs (req, ptr) and outputs (valid, id). It is parameterised by NUM_SRC.

Test Plan:
1. Reset with rst=0 mid-SERVICE, then release -> irq_out=0, irq_id=0, all registers 0, CLAIM reads 0x00000000.
2. ENABLE=0xFF, EDGE=0x00, src_irq=0x24 -> irq_out=1 with irq_id=2 two cycles later. After irq_ack and irq_complete, the next win is irq_id=5 (rr_ptr=3).
3. EDGE=0x01, one-cycle pulse on src0 -> PENDING=0x01, irq_out=1. Ack -> PENDING=0x00, state SERVICE. CLAIM write of 1 is ignored; CLAIM write of 0 -> IDLE.
4. Level src3 raised, then dropped in ASSERT before ack -> irq_out falls the next cycle and state returns to IDLE. Ack and drop in the same cycle -> SERVICE.
5. Edge src1 re-pulses while in SERVICE for id 1 -> pending[1] stays 1, irq_out stays 0. After complete, irq_out=1 with id=1 one cycle later.
6. ENABLE=0x00 with src_irq=0xFF -> irq_out stays 0. Write ENABLE=0x80 -> irq_id=7 and irq_out=1 two cycles after the write.

Source files
------------

// File: rtl/irq_arbiter_pkg.sv
// Shared definitions for the external-interrupt arbiter: register offsets,
// FSM state encoding and the machine-external-interrupt cause value.
package irq_pkg;

  localparam logic [3:0] REG_ENABLE  = 4'h0;
  localparam logic [3:0] REG_EDGE    = 4'h4;
  localparam logic [3:0] REG_PENDING = 4'h8;
  localparam logic [3:0] REG_CLAIM   = 4'hC;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    SERVICE
  } irq_state_e;

  localparam logic [31:0] MCAUSE_MEI = 32'h8000_000B;

endpackage

// File: rtl/irq_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first set request at or above
// ptr, wrapping from NUM_SRC-1 back to 0.
module rr_picker #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  int unsigned      idx;
  logic [ID_W-1:0]  idx_w;

  always_comb begin
    valid = 1'b0;
    id    = '0;
    idx   = 0;
    idx_w = '0;
    for (int unsigned off = 0; off < NUM_SRC; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      idx_w = ID_W'(idx);
      if (!valid && req[idx_w]) begin
        valid = 1'b1;
        id    = idx_w;
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Machine external-interrupt arbiter: level/edge pending capture, enable mask,
// round-robin selection and raise/ack/complete handshake with the core.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned ID_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_irq,
  output logic               irq_out,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  input  logic               irq_complete,
  input  logic               cfg_we,
  input  logic [3:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata
);

  logic [NUM_SRC-1:0] enable_q, edge_q, pending_q, pending_d, src_d_q;
  logic [NUM_SRC-1:0] id_onehot, in_service_mask, eligible, edge_set, edge_clr;
  logic [ID_W-1:0]    rr_ptr_q, rr_next, irq_id_q, pick_id;
  logic               pick_valid, irq_out_q;
  logic               wr_enable, wr_edge, wr_pending, wr_claim;
  logic               ack_take, complete_hit;
  irq_state_e         state_q;

  assign wr_enable  = cfg_we && (cfg_addr[3:2] == REG_ENABLE[3:2]);
  assign wr_edge    = cfg_we && (cfg_addr[3:2] == REG_EDGE[3:2]);
  assign wr_pending = cfg_we && (cfg_addr[3:2] == REG_PENDING[3:2]);
  assign wr_claim   = cfg_we && (cfg_addr[3:2] == REG_CLAIM[3:2]);

  always_comb begin
    id_onehot = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      id_onehot[i] = (irq_id_q == ID_W'(i));
    end
  end

  assign in_service_mask = (state_q == SERVICE) ? id_onehot : '0;
  assign eligible        = pending_q & enable_q & ~in_service_mask;
  assign ack_take        = (state_q == ASSERT) && irq_ack;
  assign complete_hit    = irq_complete ||
                           (wr_claim && (cfg_wdata[ID_W-1:0] == irq_id_q));
  assign rr_next         = (irq_id_q == ID_W'(NUM_SRC - 1)) ? '0 : irq_id_q + ID_W'(1);

  // Edge bits: a new rising edge overrides a same-cycle W1C or claim clear.
  assign edge_set  = src_irq & ~src_d_q;
  assign edge_clr  = (wr_pending ? cfg_wdata[NUM_SRC-1:0] : '0) |
                     (ack_take ? id_onehot : '0);
  assign pending_d = (edge_q & (edge_set | (pending_q & ~edge_clr))) |
                     (~edge_q & src_irq);

  rr_picker #(
    .NUM_SRC(NUM_SRC),
    .ID_W   (ID_W)
  ) u_picker (
    .req  (eligible),
    .ptr  (rr_ptr_q),
    .valid(pick_valid),
    .id   (pick_id)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_q  <= '0;
      edge_q    <= '0;
      pending_q <= '0;
      src_d_q   <= '0;
    end else begin
      pending_q <= pending_d;
      src_d_q   <= src_irq;
      if (wr_enable) enable_q <= cfg_wdata[NUM_SRC-1:0];
      if (wr_edge)   edge_q   <= cfg_wdata[NUM_SRC-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      irq_out_q <= 1'b0;
      irq_id_q  <= '0;
      rr_ptr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            irq_id_q  <= pick_id;
            irq_out_q <= 1'b1;
            state_q   <= ASSERT;
          end
        end
        ASSERT: begin
          if (irq_ack) begin
            irq_out_q <= 1'b0;
            rr_ptr_q  <= rr_next;
            state_q   <= SERVICE;
          end else if (!eligible[irq_id_q]) begin
            irq_out_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        SERVICE: begin
          if (complete_hit) state_q <= IDLE;
        end
        default: begin
          irq_out_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr[3:2])
      REG_ENABLE[3:2]:  cfg_rdata[NUM_SRC-1:0] = enable_q;
      REG_EDGE[3:2]:    cfg_rdata[NUM_SRC-1:0] = edge_q;
      REG_PENDING[3:2]: cfg_rdata[NUM_SRC-1:0] = pending_q;
      default: begin
        cfg_rdata[31]       = (state_q != IDLE);
        cfg_rdata[ID_W-1:0] = irq_id_q;
      end
    endcase
  end

  assign irq_out = irq_out_q;
  assign irq_id  = irq_id_q;

  generate
    if (NUM_SRC < 32) begin : g_unused_hi
      logic unused_bits;
      assign unused_bits = ^{cfg_addr[1:0], cfg_wdata[31:NUM_SRC]};
    end else begin : g_unused_lo
      logic unused_bits;
      assign unused_bits = ^cfg_addr[1:0];
    end
  endgenerate

endmodule

// File: tb/tb_irq_arbiter.sv
// Scoreboard bench for irq_arbiter: directed scenarios then random traffic,
// each cycle's expected outputs come from a behavioural model.
module tb_irq_arbiter;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  src_irq = '0;
  logic        irq_out;
  logic [2:0]  irq_id;
  logic        irq_ack = 1'b0;
  logic        irq_complete = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic [31:0] cfg_rdata;

  always #5 clk = ~clk;

  irq_arbiter #(.NUM_SRC(8), .ID_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .src_irq     (src_irq),
    .irq_out     (irq_out),
    .irq_id      (irq_id),
    .irq_ack     (irq_ack),
    .irq_complete(irq_complete),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_rdata   (cfg_rdata)
  );

  typedef struct {
    logic        out;
    logic [2:0]  id;
    logic [3:0]  addr;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int unsigned nvec = 0;
  int unsigned nmis = 0;

  // Reference model: sets of pending/enabled sources, the source being raised
  // or serviced, and the rotating starting point for the next search.
  bit [7:0] m_en, m_edg, m_pend, m_prev;
  int       m_ptr, m_cur;
  bit       m_raised, m_busy;
  int       rd_cnt = 0;
  logic [7:0] s_cur = '0;

  task automatic m_reset();
    m_en = '0; m_edg = '0; m_pend = '0; m_prev = '0;
    m_ptr = 0; m_cur = 0; m_raised = 0; m_busy = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return {24'b0, m_en};
      2'd1:    return {24'b0, m_edg};
      2'd2:    return {24'b0, m_pend};
      default: return {(m_raised | m_busy), 28'b0, 3'(m_cur)};
    endcase
  endfunction

  task automatic m_advance(input bit [7:0] s, input bit a, input bit c, input bit w,
                           input bit [3:0] ad, input bit [31:0] wd);
    bit [7:0] elig, npend;
    bit       setb, clr, found;
    int       k;
    elig = m_pend & m_en;
    if (m_busy) elig[m_cur] = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!m_edg[i]) npend[i] = s[i];
      else begin
        setb = s[i] && !m_prev[i];
        clr  = (w && ad[3:2] == 2'd2 && wd[i]) || (m_raised && a && m_cur == i);
        npend[i] = setb || (m_pend[i] && !clr);
      end
    end
    if (!m_raised && !m_busy) begin
      found = 0;
      for (int j = 0; j < N; j++) begin
        k = (m_ptr + j) % N;
        if (!found && elig[k]) begin
          found = 1; m_cur = k; m_raised = 1;
        end
      end
    end else if (m_raised) begin
      if (a) begin
        m_raised = 0; m_busy = 1; m_ptr = (m_cur + 1) % N;
      end else if (!elig[m_cur]) m_raised = 0;
    end else if (c || (w && ad[3:2] == 2'd3 && wd[2:0] == 3'(m_cur))) begin
      m_busy = 0;
    end
    if (w && ad[3:2] == 2'd0) m_en  = wd[7:0];
    if (w && ad[3:2] == 2'd1) m_edg = wd[7:0];
    m_pend = npend;
    m_prev = s;
  endtask

  task automatic push_exp(input logic [3:0] a);
    exp_t e;
    e.out = m_raised; e.id = 3'(m_cur); e.addr = a; e.rdata = m_read(a);
    sb.push_back(e);
  endtask

  task automatic step(input logic [7:0] s, input logic a, input logic c, input logic w,
                      input logic [3:0] ad, input logic [31:0] wd);
    @(posedge clk); #1;
    rst = 1'b1; src_irq = s; irq_ack = a; irq_complete = c;
    cfg_we = w; cfg_addr = ad; cfg_wdata = wd;
    s_cur = s;
    push_exp(ad);
    m_advance(s, a, c, w, ad, wd);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      rst = 1'b0; src_irq = '0; irq_ack = 0; irq_complete = 0;
      cfg_we = 0; cfg_addr = 4'(rd_cnt * 4); cfg_wdata = '0;
      rd_cnt++;
      m_reset();
      s_cur = '0;
      push_exp(cfg_addr);
    end
  endtask

  task automatic run(input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      step(s, 0, 0, 0, 4'(rd_cnt * 4), '0);
      rd_cnt++;
    end
  endtask

  task automatic wr(input logic [3:0] ad, input logic [31:0] wd);
    step(s_cur, 0, 0, 1, ad, wd);
  endtask

  task automatic ack();
    step(s_cur, 1, 0, 0, 4'hC, '0);
  endtask

  task automatic complete();
    step(s_cur, 0, 1, 0, 4'hC, '0);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("irq_out", {31'b0, irq_out}, {31'b0, e.out});
        chk("irq_id", {29'b0, irq_id}, {29'b0, e.id});
        chk($sformatf("rdata@%h", e.addr), cfg_rdata, e.rdata);
      end
    end
  end

  initial begin : driver
    logic [7:0]  rs;
    logic        ra, rc, rw;
    logic [3:0]  rad;
    logic [31:0] rwd;
    int          drain;
    m_reset();
    do_reset(2);

    // Level sources 2 and 5; round-robin moves past 2 after service.
    wr(4'h0, 32'hFF);
    wr(4'h4, 32'h00);
    run(8'h24, 4);
    ack();
    run(8'h24, 2);
    complete();
    run(8'h24, 4);
    ack();
    run(8'h24, 1);
    complete();

    // Edge source 0: pulse, ack clears pending, mismatched claim ignored.
    run(8'h00, 1);
    wr(4'h4, 32'h01);
    run(8'h00, 2);
    run(8'h01, 1);
    run(8'h00, 3);
    ack();
    run(8'h00, 2);
    wr(4'hC, 32'h1);
    run(8'h00, 1);
    wr(4'hC, 32'h0);
    run(8'h00, 2);

    // Level source 3 dropped before ack, then ack coinciding with drop.
    wr(4'h4, 32'h00);
    run(8'h08, 3);
    run(8'h00, 3);
    run(8'h08, 3);
    step(8'h00, 1, 0, 0, 4'h8, '0);
    run(8'h00, 2);
    complete();
    run(8'h00, 2);

    // Edge source 1 re-pulsing while in service.
    wr(4'h4, 32'h02);
    run(8'h02, 1);
    run(8'h00, 3);
    ack();
    run(8'h00, 1);
    run(8'h02, 1);
    run(8'h00, 2);
    complete();
    run(8'h00, 3);
    ack();
    run(8'h00, 1);
    complete();
    run(8'h00, 2);

    // All sources masked, then only source 7 enabled.
    wr(4'h4, 32'h00);
    wr(4'h0, 32'h00);
    run(8'hFF, 4);
    wr(4'h0, 32'h80);
    run(8'hFF, 4);

    // Reset while in service.
    ack();
    run(8'hFF, 2);
    do_reset(2);
    run(8'h00, 4);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset(1);
        continue;
      end
      rs  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : s_cur;
      ra  = ($urandom_range(0, 2) == 0);
      rc  = ($urandom_range(0, 3) == 0);
      rw  = ($urandom_range(0, 3) == 0);
      rad = 4'($urandom);
      rwd = $urandom;
      if (rw && rad[3:2] == 2'd0) rwd[7:0] = rwd[7:0] | 8'($urandom);
      step(rs, ra, rc, rw, rad, rwd);
    end
    run(8'h00, 2);

    drain = 0;
    while (sb.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    #1;
    nvec++;
    if (sb.size() != 0) begin
      nmis++;
      $display("FAIL drain: got %0d entries left expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
